frisk_anim_ctrl: RTL and testbench
==================================

FRISK_ANIM_CTRL -- requirements
Module: frisk_anim_ctrl

Interface
REQ-001 Parameter ANIM_DIV, default 8: frame_clk rising edges per walk-animation step, range 1..255.
REQ-002 Clk  input  1  system clock; all state changes on posedge Clk.
REQ-003 Reset  input  1  synchronous, active-high.
REQ-004 frame_clk  input  1  vertical-sync-rate strobe, asynchronous to nothing (Clk-domain level).
REQ-005 keycode  input  8  current keyboard code: 26=up, 22=down, 4=left, 7=right, anything else = no move key.
REQ-006 status  input  4  game screen; value 3 = overworld, animation active.
REQ-007 frame_sel  output  4  sprite ROM select, 1..10, drives the Frisk ROM output mux.
REQ-008 facing  output  2  0=down, 1=up, 2=left, 3=right.
REQ-009 walking  output  1  high while state is WALK.
REQ-010 anim_tick  output  1  one-Clk pulse on every animation step advance.

Function
REQ-011 frame_clk rise detection: frame_tick SHALL be a registered pulse, high for exactly one Clk when frame_clk was 0 at the previous posedge and is 1 at the current one.
REQ-012 Divider: 8-bit div_cnt SHALL increment on each frame_tick; on frame_tick with div_cnt == ANIM_DIV-1 it SHALL wrap to 0 and raise step (internal).
REQ-013 Frame sets: down 1,2,1,3; up 4,5,4,6; left 7,8; right 9,10; idle frame = first entry of the facing direction's set (1,4,7,9).
REQ-014 Phase: 2-bit phase indexes the set; down/up wrap 3->0, left/right wrap 1->0.
REQ-015 States: IDLE, WALK, HOLD.
REQ-016 IDLE: frame_sel = idle frame; on frame_tick with a move key and status==3 -> WALK, facing = key direction, phase=0, div_cnt=0.
REQ-017 WALK: on step, phase advances and anim_tick pulses; frame_sel = set[phase] registered same edge.
REQ-018 WALK, frame_tick with no move key -> IDLE, phase=0, div_cnt=0.
REQ-019 WALK, frame_tick with a different move key -> stay WALK, facing updated, phase=0, div_cnt=0, no anim_tick that edge.
REQ-020 Any state, status != 3 -> HOLD on the next Clk (not tick-gated); frame_sel, facing frozen; div_cnt frozen.
REQ-021 HOLD, status == 3 -> IDLE, phase=0, div_cnt=0.
REQ-022 Key and status changes are sampled only on frame_tick, except REQ-020.
REQ-023 Simultaneous step and key release: release wins, no anim_tick.
REQ-024 Latency: frame_sel/facing SHALL update on the same posedge that frame_tick is high (2 Clk after frame_clk first sampled high).
REQ-025 All outputs SHALL be registered; frame_sel SHALL never leave 1..10.

Reset
REQ-026 Reset SHALL set state IDLE, facing=0, phase=0, div_cnt=0, frame_sel=1, walking=0, anim_tick=0, frame_tick=0, frame_clk delay flop=0.
REQ-027 Reset mid-WALK or mid-HOLD SHALL take effect on the next posedge, overriding all other events.

Structure
REQ-028 Package frisk_pkg SHALL hold state enum (IDLE/WALK/HOLD), direction enum, keycode constants (26/22/4/7), frame index constants 1..10, status constant OVERWORLD=3.
REQ-029 One sub-module frisk_tick_gen SHALL contain edge detection and divider, outputs frame_tick and step, inputs Clk, Reset, frame_clk, clear, enable.

Verification
REQ-030 Reset, status=3, keycode=22 held, ANIM_DIV=2 -> frame_sel 1, then 2,1,3,1 every 2 ticks, anim_tick one pulse per change.
REQ-031 WALK right at frame_sel=10, keycode 7->26 at tick -> facing=1, frame_sel=4, phase restarts, next change after 2 ticks to 5.
REQ-032 WALK left, keycode->0 on same tick as step -> IDLE, frame_sel=7, walking=0, no anim_tick.
REQ-033 WALK up frame 5, status 3->1 mid-frame -> HOLD next Clk, frame_sel stays 5 across 10 ticks; status->3 -> IDLE, frame_sel=4.
REQ-034 Reset asserted mid-WALK at frame_sel=6 -> next posedge frame_sel=1, facing=0, walking=0.
REQ-035 frame_clk held high 20 Clk -> exactly one frame_tick.

Source files
------------

// File: rtl/frisk_pkg.sv
// Shared types, key codes, sprite frame indices and frame-set helpers for Frisk's walk animation.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package frisk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam logic [7:0] KEY_UP    = 8'd26;
    localparam logic [7:0] KEY_DOWN  = 8'd22;
    localparam logic [7:0] KEY_LEFT  = 8'd4;
    localparam logic [7:0] KEY_RIGHT = 8'd7;

    localparam logic [3:0] FRM_DOWN_STAND  = 4'd1;
    localparam logic [3:0] FRM_DOWN_STEP_A = 4'd2;
    localparam logic [3:0] FRM_DOWN_STEP_B = 4'd3;
    localparam logic [3:0] FRM_UP_STAND    = 4'd4;
    localparam logic [3:0] FRM_UP_STEP_A   = 4'd5;
    localparam logic [3:0] FRM_UP_STEP_B   = 4'd6;
    localparam logic [3:0] FRM_LEFT_STAND  = 4'd7;
    localparam logic [3:0] FRM_LEFT_STEP   = 4'd8;
    localparam logic [3:0] FRM_RIGHT_STAND = 4'd9;
    localparam logic [3:0] FRM_RIGHT_STEP  = 4'd10;

    localparam logic [3:0] OVERWORLD = 4'd3;

    function automatic logic is_move_key(input logic [7:0] k);
        return (k == KEY_UP) || (k == KEY_DOWN) || (k == KEY_LEFT) || (k == KEY_RIGHT);
    endfunction

    // Only meaningful when is_move_key() is true.
    function automatic dir_t key_dir(input logic [7:0] k);
        dir_t d;
        case (k)
            KEY_UP:    d = DIR_UP;
            KEY_LEFT:  d = DIR_LEFT;
            KEY_RIGHT: d = DIR_RIGHT;
            default:   d = DIR_DOWN;
        endcase
        return d;
    endfunction

    // Vertical walks alternate stand/step-A/stand/step-B; horizontal walks alternate two poses.
    function automatic logic [3:0] frame_of(input dir_t d, input logic [1:0] ph);
        logic [3:0] f;
        case (d)
            DIR_DOWN: begin
                case (ph)
                    2'd1:    f = FRM_DOWN_STEP_A;
                    2'd3:    f = FRM_DOWN_STEP_B;
                    default: f = FRM_DOWN_STAND;
                endcase
            end
            DIR_UP: begin
                case (ph)
                    2'd1:    f = FRM_UP_STEP_A;
                    2'd3:    f = FRM_UP_STEP_B;
                    default: f = FRM_UP_STAND;
                endcase
            end
            DIR_LEFT:  f = ph[0] ? FRM_LEFT_STEP  : FRM_LEFT_STAND;
            default:   f = ph[0] ? FRM_RIGHT_STEP : FRM_RIGHT_STAND;
        endcase
        return f;
    endfunction

    function automatic logic [1:0] next_phase(input dir_t d, input logic [1:0] ph);
        logic [1:0] n;
        if (d == DIR_LEFT || d == DIR_RIGHT) begin
            n = {1'b0, ~ph[0]};
        end else begin
            n = ph + 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/frisk_tick_gen.sv
// Detects frame_clk rising edges and divides them down into animation steps.
// Latency: frame_tick 1 Clk after frame_clk is first sampled high; step is combinational with frame_tick.
// Backpressure: none; enable freezes the divider, clear zeroes it.
module frisk_tick_gen #(
    parameter int ANIM_DIV = 8
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    input  logic clear,
    input  logic enable,
    output logic frame_tick,
    output logic step
);
    import frisk_pkg::*;

    localparam logic [7:0] DIV_LAST = 8'(ANIM_DIV - 1);

    logic       frame_clk_d;
    logic [7:0] div_cnt;

    // Register a one-Clk pulse on each 0->1 transition of frame_clk.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_d <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            frame_clk_d <= frame_clk;
            frame_tick  <= frame_clk & ~frame_clk_d;
        end
    end

    // Count frame ticks while enabled; clear wins so a restart always begins a full period.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt <= 8'd0;
        end else if (clear) begin
            div_cnt <= 8'd0;
        end else if (frame_tick && enable) begin
            div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
        end
    end

    assign step = frame_tick & enable & (div_cnt == DIV_LAST);

endmodule

// File: rtl/frisk_anim_ctrl.sv
// Frisk walk-animation controller: picks the sprite frame and facing from keyboard and game screen.
// Latency: outputs update on the Clk edge where frame_tick is high; leaving the overworld freezes next Clk.
// Backpressure: none; inputs are sampled levels, outputs are registered every cycle.
module frisk_anim_ctrl
    import frisk_pkg::*;
#(
    parameter int ANIM_DIV = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic [3:0] status,
    output logic [3:0] frame_sel,
    output logic [1:0] facing,
    output logic       walking,
    output logic       anim_tick
);

    state_t     state;
    dir_t       facing_r;
    dir_t       key_dir_w;
    logic [1:0] phase;
    logic [1:0] phase_nx;
    logic       move_key;
    logic       in_overworld;
    logic       frame_tick;
    logic       step;
    logic       div_clear;
    logic       div_en;

    assign move_key     = is_move_key(keycode);
    assign key_dir_w    = key_dir(keycode);
    assign phase_nx     = next_phase(facing_r, phase);
    assign in_overworld = (status == OVERWORLD);
    assign facing       = facing_r;

    // The divider only runs while walking on the overworld; every sampled event other
    // than continuing the same walk restarts the step period.
    assign div_en    = (state == WALK) && in_overworld;
    assign div_clear = frame_tick && in_overworld &&
                       !((state == WALK) && move_key && (key_dir_w == facing_r));

    frisk_tick_gen #(
        .ANIM_DIV(ANIM_DIV)
    ) u_tick_gen (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .clear      (div_clear),
        .enable     (div_en),
        .frame_tick (frame_tick),
        .step       (step)
    );

    // Animation state machine; leaving the overworld freezes everything immediately,
    // all other decisions are taken only on frame_tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            facing_r  <= DIR_DOWN;
            phase     <= 2'd0;
            frame_sel <= FRM_DOWN_STAND;
            walking   <= 1'b0;
            anim_tick <= 1'b0;
        end else begin
            anim_tick <= 1'b0;
            if (!in_overworld) begin
                state   <= HOLD;
                walking <= 1'b0;
            end else if (frame_tick) begin
                case (state)
                    IDLE: begin
                        if (move_key) begin
                            state     <= WALK;
                            facing_r  <= key_dir_w;
                            phase     <= 2'd0;
                            frame_sel <= frame_of(key_dir_w, 2'd0);
                            walking   <= 1'b1;
                        end
                    end
                    WALK: begin
                        if (!move_key) begin
                            // Release beats a coincident step.
                            state     <= IDLE;
                            phase     <= 2'd0;
                            frame_sel <= frame_of(facing_r, 2'd0);
                            walking   <= 1'b0;
                        end else if (key_dir_w != facing_r) begin
                            facing_r  <= key_dir_w;
                            phase     <= 2'd0;
                            frame_sel <= frame_of(key_dir_w, 2'd0);
                        end else if (step) begin
                            phase     <= phase_nx;
                            frame_sel <= frame_of(facing_r, phase_nx);
                            anim_tick <= 1'b1;
                        end
                    end
                    HOLD: begin
                        state     <= IDLE;
                        phase     <= 2'd0;
                        frame_sel <= frame_of(facing_r, 2'd0);
                        walking   <= 1'b0;
                    end
                    default: begin
                        state     <= IDLE;
                        phase     <= 2'd0;
                        frame_sel <= frame_of(facing_r, 2'd0);
                        walking   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frisk_anim_ctrl.sv
// Self-checking bench for frisk_anim_ctrl with a tick-counting reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_frisk_anim_ctrl;

    localparam int D = 2;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [3:0] status;
    logic [3:0] frame_sel;
    logic [1:0] facing;
    logic       walking;
    logic       anim_tick;

    int n_checks = 0;
    int n_fail   = 0;

    frisk_anim_ctrl #(.ANIM_DIV(D)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .keycode   (keycode),
        .status    (status),
        .frame_sel (frame_sel),
        .facing    (facing),
        .walking   (walking),
        .anim_tick (anim_tick)
    );

    always #5 Clk = ~Clk;

    // Reference model: sprite = table[dir][(ticks walked since restart / D) mod 4].
    int tbl [4][4] = '{'{1, 2, 1, 3}, '{4, 5, 4, 6}, '{7, 8, 7, 8}, '{9, 10, 9, 10}};
    int m_mode;      // 0 idle, 1 walk, 2 hold
    int m_dir;
    int m_ticks;
    int m_sel;
    int m_walk;
    int m_anim;
    int m_tick;      // registered edge pulse
    int m_fcd;
    bit started = 1'b0;

    int anim_seen = 0;
    int ft_seen   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int key_to_dir(input int k);
        case (k)
            26:      return 1;
            22:      return 0;
            4:       return 2;
            7:       return 3;
            default: return -1;
        endcase
    endfunction

    // Model update at each rising clock edge.
    initial begin
        forever begin
            int t;
            int kd;
            @(posedge Clk);
            started = 1'b1;
            if (Reset) begin
                m_mode = 0; m_dir = 0; m_ticks = 0; m_sel = 1;
                m_walk = 0; m_anim = 0; m_tick = 0; m_fcd = 0;
            end else begin
                t = m_tick;
                m_tick = (frame_clk && !m_fcd) ? 1 : 0;
                m_fcd  = frame_clk ? 1 : 0;
                m_anim = 0;
                kd = key_to_dir(int'(keycode));
                if (status != 4'd3) begin
                    m_mode = 2;
                end else if (t != 0) begin
                    if (m_mode == 0) begin
                        if (kd >= 0) begin m_mode = 1; m_dir = kd; m_ticks = 0; end
                    end else if (m_mode == 1) begin
                        if (kd < 0) begin
                            m_mode = 0; m_ticks = 0;
                        end else if (kd != m_dir) begin
                            m_dir = kd; m_ticks = 0;
                        end else begin
                            m_ticks++;
                            if (m_ticks % D == 0) m_anim = 1;
                        end
                    end else begin
                        m_mode = 0; m_ticks = 0;
                    end
                end
                if (m_mode == 1)      m_sel = tbl[m_dir][(m_ticks / D) % 4];
                else if (m_mode == 0) m_sel = tbl[m_dir][0];
                m_walk = (m_mode == 1) ? 1 : 0;
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge Clk);
            if (started) begin
                chk("frame_sel", int'(frame_sel), m_sel);
                chk("facing",    int'(facing),    m_dir);
                chk("walking",   int'(walking),   m_walk);
                chk("anim_tick", int'(anim_tick), m_anim);
                chk("frame_tick", int'(dut.frame_tick), m_tick);
                if (frame_sel < 4'd1 || frame_sel > 4'd10) chk("frame_sel_range", int'(frame_sel), 1);
                if (anim_tick)      anim_seen++;
                if (dut.frame_tick) ft_seen++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int exp_seq [8] = '{1, 2, 2, 1, 1, 3, 3, 1};
        int a0;
        int f0;

        Reset = 1'b1; frame_clk = 1'b0; keycode = 8'd22; status = 4'd3;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_frame_sel", int'(frame_sel), 1);
        chk("rst_facing",    int'(facing),    0);
        chk("rst_walking",   int'(walking),   0);
        chk("rst_anim_tick", int'(anim_tick), 0);

        // Walk down with key 22 held.
        tick();
        chk("down_start_sel", int'(frame_sel), 1);
        chk("down_start_walking", int'(walking), 1);
        a0 = anim_seen;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("down_seq_%0d", i), int'(frame_sel), exp_seq[i]);
        end
        chk("down_anim_count", anim_seen - a0, 4);

        // Right, then switch to up at frame 10.
        keycode = 8'd7;
        tick();
        chk("right_sel", int'(frame_sel), 9);
        ticks(2);
        chk("right_step_sel", int'(frame_sel), 10);
        keycode = 8'd26;
        a0 = anim_seen;
        tick();
        chk("turn_up_facing", int'(facing), 1);
        chk("turn_up_sel", int'(frame_sel), 4);
        chk("turn_up_no_anim", anim_seen - a0, 0);
        tick();
        chk("turn_up_sel_1", int'(frame_sel), 4);
        tick();
        chk("turn_up_sel_2", int'(frame_sel), 5);

        // Left, then release on the tick that would step.
        keycode = 8'd4;
        tick();
        chk("left_sel", int'(frame_sel), 7);
        tick();
        keycode = 8'd0;
        a0 = anim_seen;
        tick();
        chk("release_sel", int'(frame_sel), 7);
        chk("release_walking", int'(walking), 0);
        chk("release_no_anim", anim_seen - a0, 0);

        // Up to frame 5, then leave the overworld mid-frame.
        keycode = 8'd26;
        ticks(3);
        chk("up_sel_5", int'(frame_sel), 5);
        status = 4'd1;
        @(negedge Clk);
        chk("hold_walking", int'(walking), 0);
        chk("hold_sel", int'(frame_sel), 5);
        ticks(10);
        chk("hold_sel_after_10", int'(frame_sel), 5);
        chk("hold_facing", int'(facing), 1);
        status = 4'd3;
        tick();
        chk("unhold_sel", int'(frame_sel), 4);
        chk("unhold_walking", int'(walking), 0);

        // Walk up to frame 6, then reset mid-walk.
        tick();
        ticks(6);
        chk("up_sel_6", int'(frame_sel), 6);
        Reset = 1'b1;
        @(negedge Clk);
        chk("midwalk_rst_sel", int'(frame_sel), 1);
        chk("midwalk_rst_facing", int'(facing), 0);
        chk("midwalk_rst_walking", int'(walking), 0);
        Reset = 1'b0;
        keycode = 8'd22;
        @(negedge Clk);

        // frame_clk held high for 20 Clk gives one tick.
        f0 = ft_seen;
        frame_clk = 1'b1;
        repeat (20) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        chk("single_frame_tick", ft_seen - f0, 1);

        repeat (2) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
